// File: rtl/dino_sprite_engine.sv
// Player sprite engine: jump trajectory FSM, run animation and raster-driven
// sprite-ROM addressing with a 3-clock pixel pipeline.
module dino_sprite_engine #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 72,
  parameter int NUM_FRAMES = 2,
  parameter int JUMP_FRAME = 0,
  parameter int BASE_X     = 160,
  parameter int GROUND_Y   = 160,
  parameter int JUMP_H     = 64,
  parameter int JUMP_STEP  = 4,
  parameter int HOLD_TICKS = 6,
  parameter int ANIM_TICKS = 8,
  parameter int ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hor_reg,
  input  logic [9:0]        ver_reg,
  input  logic              frame_tick,
  input  logic              SpaceFlag,
  input  logic              breakGameFlag,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              q,
  output logic              airborne,
  output logic [12:0]       DinoPosHorFrom,
  output logic [12:0]       DinoPosHorTo,
  output logic [12:0]       DinoPosVerFrom,
  output logic [12:0]       DinoPosVerTo
);

  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam int FS_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HC_W     = $clog2(HOLD_TICKS + 1);
  localparam int AC_W     = $clog2(ANIM_TICKS + 1);
  localparam logic [12:0] X_LO = 13'(BASE_X);
  localparam logic [12:0] X_HI = 13'(BASE_X + SPR_W - 1);

  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_HOLD, ST_FALL} state_t;

  state_t            state_q;
  logic [12:0]       y_off_q;
  logic [HC_W-1:0]   hold_cnt_q;
  logic [AC_W-1:0]   anim_cnt_q;
  logic [FS_W-1:0]   frame_sel_q;
  logic              jump_pend_q;
  logic              airborne_q;

  logic              advance;
  logic [13:0]       y_sum;
  logic [12:0]       top;
  logic [12:0]       bot;

  assign advance = frame_tick & ~breakGameFlag;
  assign y_sum   = {1'b0, y_off_q} + 14'(JUMP_STEP);
  assign top     = 13'(GROUND_Y) - y_off_q;
  assign bot     = top + 13'(SPR_H - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GROUND;
      y_off_q     <= '0;
      hold_cnt_q  <= '0;
      anim_cnt_q  <= '0;
      frame_sel_q <= '0;
      jump_pend_q <= 1'b0;
      airborne_q  <= 1'b0;
    end else begin
      if (state_q == ST_GROUND && SpaceFlag) jump_pend_q <= 1'b1;
      if (advance) begin
        unique case (state_q)
          ST_GROUND: begin
            if (jump_pend_q || SpaceFlag) begin
              state_q     <= ST_RISE;
              y_off_q     <= 13'(JUMP_STEP);
              jump_pend_q <= 1'b0;
              airborne_q  <= 1'b1;
            end else if (anim_cnt_q == AC_W'(ANIM_TICKS - 1)) begin
              anim_cnt_q  <= '0;
              frame_sel_q <= (frame_sel_q == FS_W'(NUM_FRAMES - 1)) ? '0
                                                                    : frame_sel_q + FS_W'(1);
            end else begin
              anim_cnt_q <= anim_cnt_q + AC_W'(1);
            end
          end
          ST_RISE: begin
            if (y_sum >= 14'(JUMP_H)) begin
              y_off_q    <= 13'(JUMP_H);
              hold_cnt_q <= '0;
              state_q    <= ST_HOLD;
            end else begin
              y_off_q <= y_sum[12:0];
            end
          end
          ST_HOLD: begin
            // Exit on the tick that finds the count already at its last value,
            // so the peak is held for HOLD_TICKS full ticks.
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
            if (hold_cnt_q == HC_W'(HOLD_TICKS - 1)) state_q <= ST_FALL;
          end
          ST_FALL: begin
            if (y_off_q <= 13'(JUMP_STEP)) begin
              y_off_q    <= '0;
              state_q    <= ST_GROUND;
              airborne_q <= 1'b0;
            end else begin
              y_off_q <= y_off_q - 13'(JUMP_STEP);
            end
          end
          default: state_q <= ST_GROUND;
        endcase
      end
    end
  end

  logic [FS_W-1:0]   frame_sel;
  logic [12:0]       hor_ext;
  logic [12:0]       ver_ext;
  logic [12:0]       dv;
  logic [12:0]       dh;
  logic              hit_d;
  logic [ADDR_W-1:0] rom_addr_d;

  logic              hit_d1_q;
  logic              hit_d2_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              q_q;

  assign frame_sel = airborne_q ? FS_W'(JUMP_FRAME) : frame_sel_q;
  assign hor_ext   = {2'b00, hor_reg};
  assign ver_ext   = {3'b000, ver_reg};
  assign dv        = ver_ext - top;
  assign dh        = hor_ext - X_LO;

  always_comb begin
    hit_d      = (hor_ext >= X_LO) && (hor_ext <= X_HI) &&
                 (ver_ext >= top)  && (ver_ext <= bot);
    rom_addr_d = '0;
    if (hit_d)
      rom_addr_d = ADDR_W'(32'(frame_sel) * 32'(FRAME_SZ) +
                           32'(dv) * 32'(SPR_W) + 32'(dh));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d1_q   <= 1'b0;
      hit_d2_q   <= 1'b0;
      rom_addr_q <= '0;
      q_q        <= 1'b0;
    end else begin
      hit_d1_q   <= hit_d;
      rom_addr_q <= rom_addr_d;
      hit_d2_q   <= hit_d1_q;
      q_q        <= rom_data & hit_d2_q;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign q              = q_q;
  assign airborne       = airborne_q;
  assign DinoPosHorFrom = X_LO;
  assign DinoPosHorTo   = X_HI;
  assign DinoPosVerFrom = top;
  assign DinoPosVerTo   = bot;

endmodule

// File: tb/tb_dino_sprite_engine.sv
// Bench for dino_sprite_engine: directed steps plus random traffic checked
// against a tick-count trajectory/animation model and a bench-side ROM.
module tb_dino_sprite_engine;

  logic        clk = 1'b0;
  logic        rst, frame_tick, SpaceFlag, breakGameFlag;
  logic [10:0] hor_reg;
  logic [9:0]  ver_reg;
  logic [12:0] rom_addr;
  logic        rom_data;
  logic        q, airborne;
  logic [12:0] hf, ht, vf, vt;

  always #5 clk = ~clk;

  dino_sprite_engine dut (
    .clk(clk), .rst(rst), .hor_reg(hor_reg), .ver_reg(ver_reg),
    .frame_tick(frame_tick), .SpaceFlag(SpaceFlag), .breakGameFlag(breakGameFlag),
    .rom_addr(rom_addr), .rom_data(rom_data), .q(q), .airborne(airborne),
    .DinoPosHorFrom(hf), .DinoPosHorTo(ht), .DinoPosVerFrom(vf), .DinoPosVerTo(vt)
  );

  bit rom [0:4607];
  always @(posedge clk) rom_data <= (rom_addr < 13'd4608) ? rom[rom_addr] : 1'b0;

  int total = 0;
  int bad   = 0;

  // Model: jt = ticks since jump start (0 = grounded), gticks = grounded run ticks.
  int jt = 0;
  int gticks = 0;
  bit pend = 0;
  int p1_hit = 0, p1_addr = 0, p2_hit = 0, p2_addr = 0;

  function automatic int traj(int t);
    if (t <= 16) return 4 * t;
    else if (t <= 22) return 64;
    else return 64 - 4 * (t - 22);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit tk, bit sp, bit fz, int h, int v);
    int top, fsel, chit, caddr, expq;
    @(negedge clk);
    rst = r; frame_tick = tk; SpaceFlag = sp; breakGameFlag = fz;
    hor_reg = 11'(h); ver_reg = 10'(v);
    top   = 160 - traj(jt);
    fsel  = (jt != 0) ? 0 : (gticks / 8) % 2;
    chit  = (h >= 160 && h <= 191 && v >= top && v <= top + 71) ? 1 : 0;
    caddr = (chit != 0) ? fsel * 2304 + (v - top) * 32 + (h - 160) : 0;
    @(posedge clk);
    if (r) begin
      jt = 0; gticks = 0; pend = 0;
      chit = 0; caddr = 0; p1_hit = 0; p2_hit = 0;
    end else if (tk && !fz) begin
      if (jt == 0) begin
        if (pend || sp) begin jt = 1; pend = 0; end
        else gticks++;
      end else begin
        jt++;
        if (jt == 38) jt = 0;
      end
    end else if (sp && jt == 0) begin
      pend = 1;
    end
    #1;
    expq = (p2_hit != 0) ? int'(rom[p2_addr]) : 0;
    chk("rom_addr", rom_addr, caddr);
    chk("q", q, expq);
    chk("ver_from", vf, 160 - traj(jt));
    chk("ver_to", vt, 231 - traj(jt));
    chk("hor_from", hf, 160);
    chk("hor_to", ht, 191);
    chk("airborne", airborne, (jt != 0) ? 1 : 0);
    p2_hit = p1_hit; p2_addr = p1_addr;
    p1_hit = chit;   p1_addr = caddr;
  endtask

  task automatic pix(int n, bit sp);
    repeat (n) step(0, 0, sp, 0, $urandom_range(150, 200), $urandom_range(80, 240));
  endtask

  task automatic tick(bit sp, bit fz);
    step(0, 1, sp, fz, $urandom_range(150, 200), $urandom_range(80, 240));
  endtask

  initial begin
    int seq;
    rst = 1'b1; frame_tick = 1'b0; SpaceFlag = 1'b0; breakGameFlag = 1'b0;
    hor_reg = '0; ver_reg = '0;
    for (int i = 0; i < 4608; i++) rom[i] = 1'b1;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_ver_from", vf, 160);
    chk("rst_ver_to", vt, 231);
    chk("rst_q", q, 0);

    // Raster scan around the grounded sprite with an all-ones ROM.
    seq = 0;
    for (int v = 150; v <= 240; v++) begin
      for (int h = 150; h <= 200; h++) begin
        step(0, 0, 0, 0, h, v);
        if (h >= 160 && h <= 191 && v >= 160 && v <= 231) begin
          chk("raster_seq", rom_addr, seq);
          seq++;
        end
      end
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4608; i++) rom[i] = 1'($urandom_range(0, 1));

    // Run animation: frame 1 after 8 ticks, back to 0 after 16.
    repeat (8) begin tick(0, 0); pix(6, 0); end
    step(0, 0, 0, 0, 170, 170);
    chk("anim_frame1_addr", rom_addr, 2634);
    repeat (8) begin tick(0, 0); pix(6, 0); end
    step(0, 0, 0, 0, 170, 170);
    chk("anim_frame0_addr", rom_addr, 330);

    // One-cycle jump pulse, freeze mid-rise, then full trajectory.
    step(0, 0, 1, 0, 0, 0);
    pix(4, 0);
    for (int t = 1; t <= 8; t++) begin tick(0, 0); pix(4, 0); end
    chk("rise_y32", vf, 128);
    repeat (10) begin tick(0, 1); pix(3, 0); end
    chk("freeze_hold", vf, 128);
    step(0, 0, 0, 0, 170, 138);
    chk("air_addr", rom_addr, 330);
    for (int t = 9; t <= 38; t++) begin
      tick(0, 0);
      if (t == 16) chk("peak", vf, 96);
      if (t == 22) chk("hold_end", vf, 96);
      if (t == 23) chk("fall_start", vf, 100);
      pix(3, 0);
    end
    chk("landed_air", airborne, 0);
    chk("landed_ver", vf, 160);

    // Reset during HOLD.
    step(0, 0, 1, 0, 0, 0);
    repeat (18) begin tick(0, 0); pix(2, 0); end
    step(1, 0, 0, 0, 170, 170);
    chk("rst_hold_air", airborne, 0);
    chk("rst_hold_ver", vf, 160);
    chk("rst_hold_q", q, 0);
    pix(3, 0);

    // SpaceFlag held high: one jump, next starts on first tick after landing.
    for (int t = 1; t <= 39; t++) begin
      tick(1, 0);
      if (t == 38) chk("held_land", airborne, 0);
      pix(3, 1);
    end
    chk("held_rejump", vf, 156);

    // Random traffic.
    repeat (3000) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           $urandom_range(140, 210), $urandom_range(80, 250));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
